// File: rtl/tdc_merger_pkg.sv
// tdc_merger_pkg: register offsets, entry field positions and limits for the TDC event merger
package tdc_merger_pkg;
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_DATA   = 3'd1;
    localparam logic [2:0] REG_POP    = 3'd2;
    localparam logic [2:0] REG_MASK   = 3'd3;
    localparam logic [2:0] REG_THRESH = 3'd4;
    localparam logic [2:0] REG_OVFCNT = 3'd5;
    localparam logic [2:0] REG_HWM    = 3'd6;
    localparam int ENT_VALID    = 31;
    localparam int ENT_POL      = 30;
    localparam int ENT_CHAN_MSB = 29;
    localparam int ENT_CHAN_LSB = 25;
    localparam int ENT_TS_MSB   = 24;
    localparam int MAX_NCHAN    = 32;
    localparam int MAX_TS_WIDTH = 25;
    localparam int ENT_WIDTH    = ENT_VALID;
endpackage

// File: rtl/tdc_merger_fifo.sv
// tdc_merger_fifo: first-word-fall-through FIFO with level output; a pop frees the slot for a same-cycle push when full
module tdc_merger_fifo #(
    parameter int WIDTH      = 31,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);
    localparam int LW = DEPTH_LOG2 + 1;
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic do_pop, do_push;
    assign full    = level[DEPTH_LOG2];
    assign do_pop  = pop && level != '0;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];
    // advance pointers and track occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    // entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/tdc_event_merger.sv
// tdc_event_merger: round-robin merge of NCHAN TDC event channels into one CSR-readable FIFO; TDC_MERGER_HWM_EN adds the high-water-mark register
module tdc_event_merger
    import tdc_merger_pkg::*;
#(
    parameter logic [3:0] csr_addr        = 4'h2,
    parameter int         NCHAN           = 2,
    parameter int         TS_WIDTH        = 24,
    parameter int         FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [13:0]               csr_a,
    input  logic                      csr_we,
    input  logic [31:0]               csr_di,
    output logic [31:0]               csr_do,
    input  logic [NCHAN-1:0]          ev_valid_i,
    input  logic [NCHAN-1:0]          ev_pol_i,
    input  logic [NCHAN*TS_WIDTH-1:0] ev_ts_i,
    output logic [NCHAN-1:0]          ev_ack_o,
    output logic                      irq
);
    localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
    localparam int LW = FIFO_DEPTH_LOG2 + 1;
    logic [CW-1:0] rr, gnt_idx, gidx_q;
    logic [NCHAN-1:0] req, mask;
    logic gnt_any, gv_q, gpol_q;
    logic [TS_WIDTH-1:0] gts_q;
    logic [LW-1:0] level, thresh;
    logic [ENT_WIDTH-1:0] head;
    logic full, sel, wr, pop, push_req, ovf, sticky;
    logic [2:0] off;
    logic [31:0] ovfcnt, rdata, hwm_rd;
    logic unused_bits;
    assign unused_bits = ^{csr_a[9:3], csr_di};
    // the channel acked this cycle was granted last cycle, so its valid is stale
    assign req      = ev_valid_i & ~ev_ack_o;
    assign sel      = csr_a[13:10] == csr_addr;
    assign wr       = sel && csr_we;
    assign off      = csr_a[2:0];
    assign pop      = wr && off == REG_POP;
    assign push_req = gv_q && mask[gidx_q];
    assign ovf      = push_req && full && !pop;
    // round-robin search from rr; descending scan leaves the nearest requester
    always_comb begin
        logic [CW-1:0] j;
        gnt_any = 1'b0;
        gnt_idx = '0;
        j = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            j = CW'((int'(rr) + i) % NCHAN);
            if (req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = j;
            end
        end
    end
    // register the grant: ack pulse plus captured event for next-cycle write
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rr       <= '0;
            ev_ack_o <= '0;
            gv_q     <= 1'b0;
            gidx_q   <= '0;
            gpol_q   <= 1'b0;
            gts_q    <= '0;
        end else begin
            ev_ack_o <= gnt_any ? NCHAN'(1) << gnt_idx : '0;
            gv_q     <= gnt_any;
            gidx_q   <= gnt_idx;
            gpol_q   <= ev_pol_i[gnt_idx];
            gts_q    <= ev_ts_i[gnt_idx*TS_WIDTH +: TS_WIDTH];
            if (gnt_any) rr <= gnt_idx == CW'(NCHAN - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
    tdc_merger_fifo #(.WIDTH(ENT_WIDTH), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push_req),
        .pop   (pop),
        .din   ({gpol_q, 5'(gidx_q), MAX_TS_WIDTH'(gts_q)}),
        .head  (head),
        .level (level),
        .full  (full)
    );
    // control registers, overflow accounting and interrupt
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mask   <= '1;
            thresh <= LW'(1);
            ovfcnt <= '0;
            sticky <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr && off == REG_MASK) mask <= csr_di[NCHAN-1:0];
            if (wr && off == REG_THRESH) thresh <= csr_di[LW-1:0];
            ovfcnt <= (wr && off == REG_OVFCNT) ? 32'(ovf) : ovfcnt + 32'(ovf && ovfcnt != '1);
            sticky <= ovf || (sticky && !(wr && off == REG_STATUS && csr_di[31]));
            irq    <= sticky || (thresh != '0 && level >= thresh);
        end
    end
`ifdef TDC_MERGER_HWM_EN
    logic [LW-1:0] hwm;
    // peak level since reset or since the last write, which reloads the current level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) hwm <= '0;
        else hwm <= (wr && off == REG_HWM) || level > hwm ? level : hwm;
    end
    assign hwm_rd = 32'(hwm);
`else
    assign hwm_rd = '0;
`endif
    // read mux for the addressed register
    always_comb begin
        case (off)
            REG_STATUS: rdata = {sticky, 31'(level)};
            REG_DATA:   rdata = level == '0 ? '0 : {1'b1, head};
            REG_MASK:   rdata = 32'(mask);
            REG_THRESH: rdata = 32'(thresh);
            REG_OVFCNT: rdata = ovfcnt;
            REG_HWM:    rdata = hwm_rd;
            default:    rdata = '0;
        endcase
    end
    // registered read data, zero when the page is not selected
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) csr_do <= '0;
        else csr_do <= sel ? rdata : '0;
    end
endmodule
